// File: rtl/bsg_link_pkg.sv
// Shared types and helpers for the OSDR link transmit side.
package bsg_link_pkg;

  // Transmitter lifecycle: quiet period after reset, normal sending, and a
  // terminal state entered when the receiver returns more credits than exist.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } link_state_e;

  // Credit counter must represent 0..2^lg_depth inclusive, hence one extra bit.
  function automatic int credit_width(input int lg_depth);
    return lg_depth + 1;
  endfunction

endpackage

// File: rtl/bsg_link_token_sync.sv
// Brings the receiver's asynchronous credit token into clk_i and turns every
// toggle (rising or falling) into a single-cycle edge pulse.
module bsg_link_token_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic token_i,
  output logic edge_o
);

  logic sync1;
  logic sync2;
  logic last;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      last  <= 1'b0;
    end else begin
      sync1 <= token_i;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  assign edge_o = sync2 ^ last;

endmodule

// File: rtl/bsg_link_osdr_tx_credit.sv
// Credit-based transmit front end for the OSDR link. Accepts words from the
// core only while the remote FIFO is known to have room, registers them for
// the output stage, and recovers credits from the receiver's toggle token.
//
// Handshake: a word moves when v_i and ready_o are both 1 in the same cycle.
// ready_o is a flop output and never looks at v_i; the producer may hold v_i
// and data_i until it sees ready_o, and must not drop a word it offered while
// ready_o was high.
module bsg_link_osdr_tx_credit
  import bsg_link_pkg::*;
#(
  parameter int width_p                         = 16,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 1,
  parameter int init_cycles_p                   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic                       token_i,
  output logic [width_p-1:0]         io_data_o,
  output logic                       io_v_o,
  output logic                       error_o,
  output link_state_e                dbg_state_o,
  output logic [lg_fifo_depth_p:0]   dbg_credit_o
);

  localparam int credit_w = credit_width(lg_fifo_depth_p);
  localparam int sum_w    = credit_w + 1;
  localparam int init_w   = $clog2(init_cycles_p + 1);

  localparam logic [sum_w-1:0]  credit_max = sum_w'(2 ** lg_fifo_depth_p);
  localparam logic [sum_w-1:0]  token_gain = sum_w'(2 ** lg_credit_to_token_decimation_p);
  localparam logic [init_w-1:0] init_last  = init_w'(init_cycles_p - 1);

  link_state_e          state;
  link_state_e          state_next;
  logic [init_w-1:0]    init_cnt;
  logic [init_w-1:0]    init_cnt_next;

  logic [credit_w-1:0]  credit_r;
  logic [credit_w-1:0]  credit_next;
  logic [sum_w-1:0]     credit_sum;
  logic                 overflow;

  logic                 token_edge;
  logic                 transfer;
  logic                 deliver;
  logic                 ready_next;

  logic                 ready_r;
  logic                 io_v_r;
  logic [width_p-1:0]   io_data_r;
  logic                 error_r;

  bsg_link_token_sync token_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .token_i (token_i),
    .edge_o  (token_edge)
  );

  assign transfer = v_i & ready_r;

  // Credit arithmetic: spend one per accepted word, gain a block per token edge.
  always_comb begin
    credit_sum  = {1'b0, credit_r}
                - {{(sum_w-1){1'b0}}, transfer}
                + (token_edge ? token_gain : '0);
    overflow    = (state != ST_ERROR) && (credit_sum > credit_max);
    credit_next = credit_r;
    if (state != ST_ERROR) begin
      if (overflow) credit_next = credit_max[credit_w-1:0];
      else          credit_next = credit_sum[credit_w-1:0];
    end
  end

  // Next-state logic: quiet count, normal run, sticky error on overflow.
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    case (state)
      ST_INIT: begin
        if (overflow)                   state_next = ST_ERROR;
        else if (init_cnt == init_last) state_next = ST_ACTIVE;
        else                            init_cnt_next = init_cnt + 1'b1;
      end
      ST_ACTIVE: begin
        if (overflow) state_next = ST_ERROR;
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
      end
      default: begin
        state_next = ST_ERROR;
      end
    endcase
  end

  // ready is precomputed for next cycle so the output stays a plain flop.
  // A word accepted in the overflow cycle is not forwarded: error dominates.
  assign ready_next = (state_next == ST_ACTIVE) && (credit_next != '0);
  assign deliver    = transfer & ~overflow;

  // FSM state register and quiet-period counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  // Credit counter and registered link outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_r  <= credit_max[credit_w-1:0];
      ready_r   <= 1'b0;
      io_v_r    <= 1'b0;
      io_data_r <= '0;
      error_r   <= 1'b0;
    end else begin
      credit_r <= credit_next;
      ready_r  <= ready_next;
      io_v_r   <= deliver;
      if (deliver) io_data_r <= data_i;
      error_r  <= (state_next == ST_ERROR);
    end
  end

  assign ready_o      = ready_r;
  assign io_v_o       = io_v_r;
  assign io_data_o    = io_data_r;
  assign error_o      = error_r;
  assign dbg_state_o  = state;
  assign dbg_credit_o = credit_r;

endmodule

// File: tb/tb_bsg_link_osdr_tx_credit.sv
// Bench for bsg_link_osdr_tx_credit: directed scenarios plus a cycle model of
// credits, quiet period and token latency, compared every cycle.
module tb_bsg_link_osdr_tx_credit;
  import bsg_link_pkg::*;

  localparam int W        = 16;
  localparam int FULL     = 8;
  localparam int GAIN     = 2;
  localparam int QUIET    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_i;
  logic [W-1:0]  data_i;
  logic          v_i;
  logic          ready_o;
  logic          token_i;
  logic [W-1:0]  io_data_o;
  logic          io_v_o;
  logic          error_o;
  link_state_e   dbg_state_o;
  logic [3:0]    dbg_credit_o;

  always #5 clk = ~clk;

  bsg_link_osdr_tx_credit #(
    .width_p(16), .lg_fifo_depth_p(3),
    .lg_credit_to_token_decimation_p(1), .init_cycles_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .token_i(token_i), .io_data_o(io_data_o),
    .io_v_o(io_v_o), .error_o(error_o), .dbg_state_o(dbg_state_o),
    .dbg_credit_o(dbg_credit_o)
  );

  int check_count = 0;
  int fail_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Credits are an integer budget; the quiet period is "cycles since reset";
  // a token change seen at edge n is credited on edge n+2 (two sync stages).
  int            m_credit = FULL;
  int            m_since  = 0;
  bit            m_err    = 0;
  bit            m_ready  = 0;
  bit            m_v      = 0;
  logic [W-1:0]  m_data   = '0;
  bit            m_live   = 0;
  logic          tok_hist[3];
  logic [W-1:0]  exp_q[$];

  always @(posedge clk) begin
    int newc;
    bit xfer;
    if (reset_i) begin
      m_credit = FULL; m_since = 0; m_err = 0; m_ready = 0; m_v = 0; m_data = '0;
      for (int i = 0; i < 3; i++) tok_hist[i] = 1'b0;
      exp_q.delete();
      m_live = 1;
    end else begin
      xfer = v_i && m_ready;
      if (!m_err) begin
        newc = m_credit - int'(xfer) + ((tok_hist[1] != tok_hist[2]) ? GAIN : 0);
        if (newc > FULL) begin m_credit = FULL; m_err = 1; end
        else m_credit = newc;
      end
      m_v = xfer && !m_err;
      if (m_v) begin m_data = data_i; exp_q.push_back(data_i); end
      tok_hist[2] = tok_hist[1]; tok_hist[1] = tok_hist[0]; tok_hist[0] = token_i;
      if (m_since < 1000) m_since++;
      m_ready = !m_err && (m_since >= QUIET) && (m_credit > 0);
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0] st_exp;
    logic [W-1:0] front;
    if (m_live) begin
      st_exp = m_err ? ST_ERROR : ((m_since >= QUIET) ? ST_ACTIVE : ST_INIT);
      check("cyc_ready",  ready_o,      m_ready);
      check("cyc_io_v",   io_v_o,       m_v);
      check("cyc_data",   io_data_o,    m_data);
      check("cyc_error",  error_o,      m_err);
      check("cyc_credit", dbg_credit_o, m_credit);
      check("cyc_state",  dbg_state_o,  st_exp);
      if (io_v_o) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          front = exp_q.pop_front();
          check("sb_word", io_data_o, front);
        end
      end
    end
  end

  // Count output pulses and keep recently delivered words.
  int            n_out = 0;
  logic [W-1:0]  seen_q[$];
  always @(posedge clk) begin
    #1;
    if (io_v_o) begin n_out++; seen_q.push_back(io_data_o); end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_i = 1'b1; token_i = 1'b0; v_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input int budget, output bit ok);
    ok = 0; data_i = d; v_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (ready_o) begin @(negedge clk); ok = 1; break; end
      @(negedge clk);
    end
    v_i = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cnt, out0, rx_count, rx_max, consumed, tx_cnt;
    bit ok;
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; token_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",  ready_o, 0);
    check("rst_io_v",   io_v_o, 0);
    check("rst_error",  error_o, 0);
    check("rst_data",   io_data_o, 0);
    check("rst_credit", dbg_credit_o, 8);
    check("rst_state",  dbg_state_o, ST_INIT);

    // Quiet period with v_i held, then a burst that drains all 8 credits
    v_i = 1'b1; data_i = W'($urandom_range(0, 65535)); reset_i = 1'b0;
    cnt = 0;
    while (!ready_o && cnt < 20) begin
      cnt++; @(negedge clk); data_i = W'($urandom_range(0, 65535));
    end
    check("init_quiet_cycles", cnt, 4);
    out0 = n_out;
    repeat (16) begin @(negedge clk); data_i = W'($urandom_range(0, 65535)); end
    check("burst_pulses", n_out - out0, 8);
    check("burst_ready",  ready_o, 0);
    check("burst_credit", dbg_credit_o, 0);
    v_i = 1'b0;
    @(negedge clk);

    // One token toggle returns exactly two words of room
    token_i = ~token_i;
    repeat (3) @(negedge clk);
    check("token_credit", dbg_credit_o, 2);
    out0 = n_out;
    send(16'hA5A5, 10, ok); check("send_a5a5", ok, 1);
    send(16'h5A5A, 10, ok); check("send_5a5a", ok, 1);
    send(16'hFFFF, 8, ok);  check("send_blocked", ok, 0);
    check("token_words", n_out - out0, 2);
    if (seen_q.size() >= 2) begin
      check("word0", seen_q[seen_q.size()-2], 16'hA5A5);
      check("word1", seen_q[seen_q.size()-1], 16'h5A5A);
    end else check("word_count", seen_q.size(), 2);
    check("token_credit_empty", dbg_credit_o, 0);

    // Transfer and token edge in the same cycle at credit 1
    token_i = ~token_i;
    repeat (3) @(negedge clk);
    send(16'h1111, 10, ok); check("send_1111", ok, 1);
    check("credit_one", dbg_credit_o, 1);
    token_i = ~token_i;
    repeat (2) @(negedge clk);
    data_i = 16'h2222; v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    check("same_cycle_credit", dbg_credit_o, 2);
    check("same_cycle_io_v",   io_v_o, 1);
    check("same_cycle_data",   io_data_o, 16'h2222);

    // Token edge with full credits is an overflow and sticks until reset
    do_reset();
    repeat (5) @(negedge clk);
    check("full_ready", ready_o, 1);
    token_i = ~token_i;
    repeat (3) @(negedge clk);
    check("ovf_error",  error_o, 1);
    check("ovf_ready",  ready_o, 0);
    check("ovf_state",  dbg_state_o, ST_ERROR);
    check("ovf_credit", dbg_credit_o, 8);
    out0 = n_out; v_i = 1'b1;
    repeat (6) @(negedge clk);
    v_i = 1'b0;
    check("ovf_no_output", n_out - out0, 0);
    check("ovf_sticky", error_o, 1);

    // Reset in the cycle a word is accepted discards it
    do_reset();
    @(negedge clk);
    check("rst_clears_error", error_o, 0);
    repeat (4) @(negedge clk);
    check("pre_abort_ready", ready_o, 1);
    data_i = 16'h1234; v_i = 1'b1; reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; v_i = 1'b0;
    check("abort_io_v",   io_v_o, 0);
    check("abort_credit", dbg_credit_o, 8);
    check("abort_state",  dbg_state_o, ST_INIT);
    repeat (5) @(negedge clk);

    // Random traffic against an 8-entry receiver returning tokens per 2 words
    rx_count = 0; rx_max = 0; consumed = 0; tx_cnt = 0; out0 = n_out;
    for (int c = 0; c < 460; c++) begin
      if (io_v_o) rx_count++;
      if (rx_count > rx_max) rx_max = rx_count;
      if (rx_count > 0 && $urandom_range(0, 2) == 0) begin
        rx_count--; consumed++;
        if (consumed == 2) begin consumed = 0; token_i = ~token_i; end
      end
      if (c < 400) begin
        v_i = 1'($urandom_range(0, 1));
        data_i = W'($urandom_range(0, 65535));
      end else v_i = 1'b0;
      if (v_i && ready_o) tx_cnt++;
      @(negedge clk);
    end
    if (io_v_o) rx_count++;
    check("rand_rx_bound", rx_max <= FULL, 1);
    check("rand_no_error", error_o, 0);
    check("rand_no_loss",  n_out - out0, tx_cnt);
    check("rand_sb_empty", exp_q.size(), 0);
    check("rand_credit",   dbg_credit_o, FULL - rx_count - consumed);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/bsg_link_osdr_tx_credit.md
BSG_LINK_OSDR_TX_CREDIT -- requirements
Module: bsg_link_osdr_tx_credit

Interface
REQ-001 Parameter width_p, default 16, payload width per link word.
REQ-002 Parameter lg_fifo_depth_p, default 3, log2 of receiver FIFO depth; initial credits = 2^lg_fifo_depth_p.
REQ-003 Parameter lg_credit_to_token_decimation_p, default 1, log2 of credits returned per token edge; SHALL be <= lg_fifo_depth_p.
REQ-004 Parameter init_cycles_p, default 4, quiet cycles after reset, >= 1.
REQ-005 clk_i  in  1  core clock, also the clock fed to the OSDR phase-align stage; one clock only.
REQ-006 reset_i  in  1  reset, synchronous and active-high.
REQ-007 data_i  in  width_p  payload from core.
REQ-008 v_i  in  1  payload valid (valid/ready handshake).
REQ-009 ready_o  out  1  block accepts data_i this cycle.
REQ-010 token_i  in  1  asynchronous toggle from receiver; each edge (rise or fall) returns 2^lg_credit_to_token_decimation_p credits.
REQ-011 io_data_o  out  width_p  registered link data to OSDR output stage.
REQ-012 io_v_o  out  1  registered link valid to OSDR output stage.
REQ-013 error_o  out  1  sticky credit-overflow flag.

Function
REQ-014 Transfer occurs in a cycle with v_i=1 and ready_o=1; ready_o SHALL NOT depend on v_i.
REQ-015 ready_o = (state==ACTIVE) and (credit_r != 0), from registers only.
REQ-016 On transfer, io_data_o<=data_i and io_v_o<=1 on the next clk_i edge; latency exactly 1 cycle.
REQ-017 Without transfer, io_v_o<=0 and io_data_o holds its previous value.
REQ-018 credit_r SHALL be lg_fifo_depth_p+1 bits, range 0..2^lg_fifo_depth_p.
REQ-019 Per cycle: credit_next = credit_r - transfer + (token_edge ? 2^lg_credit_to_token_decimation_p : 0); transfer and token edge in the same cycle both apply.
REQ-020 token_i SHALL pass a 2-flop synchronizer then edge detect against a third flop; one token_edge pulse per toggle, 3-cycle worst-case latency.
REQ-021 If credit_next exceeds 2^lg_fifo_depth_p: credit_r saturates at max, error_o<=1, state<=ERROR.
REQ-022 FSM states INIT, ACTIVE, ERROR.
REQ-023 INIT: counter counts init_cycles_p cycles, ready_o=0, tokens still counted; then ACTIVE.
REQ-024 ACTIVE: normal operation; to ERROR on overflow only.
REQ-025 ERROR: ready_o=0, io_v_o=0, error_o=1; exit only by reset.
REQ-026 A token edge arriving in INIT that overflows SHALL also enter ERROR.

Reset
REQ-027 reset_i SHALL be sampled only on clk_i rising edges.
REQ-028 While reset_i=1 and the cycle after deassertion: state=INIT, credit_r=2^lg_fifo_depth_p, io_v_o=0, io_data_o=0, error_o=0, ready_o=0, synchronizer and edge flops=0, init counter=0.
REQ-029 Reset mid-transfer SHALL discard the in-flight word (io_v_o=0 next cycle); credits restore to full.

Structure
REQ-030 FSM state enum and the credit/token width helper constant belong in shared package bsg_link_pkg.
REQ-031 Synchronizer plus edge detector SHALL be sub-module bsg_link_token_sync (ports clk_i, reset_i, token_i, edge_o).
REQ-032 All outputs driven from flops; no combinational path from token_i or v_i to any output.

Verification (width_p=16, lg_fifo_depth_p=3, decimation=1, init_cycles_p=4)
REQ-033 Reset, v_i=1 held -> ready_o=0 for 4 cycles after deassertion, then 8 transfers, io_v_o pulses 8 times, ready_o=0 with credit_r=0.
REQ-034 credit_r=0, one token_i toggle -> within 3 cycles credit_r=2, exactly 2 more words 0xA5A5, 0x5A5A appear on io_data_o.
REQ-035 credit_r=1, transfer and token edge same cycle -> credit_r=2 next cycle.
REQ-036 credit_r=8 (full), one token toggle -> error_o=1, ready_o=0, io_v_o=0 until reset.
REQ-037 Reset asserted in the transfer cycle of 0x1234 -> io_v_o=0 next cycle, credit_r=8, state=INIT.
REQ-038 Random v_i with token returns modelled by an 8-entry receiver -> output word sequence equals input sequence, no overflow, no loss.
